// File: rtl/uart_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_arb_pkg: shared types and constants for the UART TX arbiter     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_arb_pkg;

  localparam int BYTE_W           = 8;
  localparam int DEF_NUM_REQ      = 3;
  localparam int DEF_LOCK_TIMEOUT = 27000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick: combinational round-robin picker, first request at or above |
// | ptr with wrap-around.   Revision: 1.0                                |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant,
  output logic               any_req
);

  // Walk from farthest to nearest so the nearest request is the last write.
  always_comb begin
    grant   = '0;
    any_req = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        grant = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter: message-level round-robin sharing of the UART TX    |
// | path, with lock timeout recovery.   Revision: 1.0                    |
// +----------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int ID_W         = 2
) (
  input  logic                      system_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ack,
  input  logic                      uart_tx_fifo_ready,
  output logic                      start_uart_tx,
  output logic [BYTE_W-1:0]         uart_tx_data,
  output logic [ID_W-1:0]           owner,
  output logic                      locked,
  output logic                      lock_timeout
);

  localparam int c_cnt_w = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(LOCK_TIMEOUT - 1);

  arb_state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]      r_owner, w_owner_nxt;
  logic [ID_W-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic                 r_locked, w_locked_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
  logic                 r_start, w_start_nxt;
  logic [NUM_REQ-1:0]   r_ack, w_ack_nxt;
  logic [BYTE_W-1:0]    r_data, w_data_nxt;
  logic                 r_timeout, w_timeout_nxt;

  logic [ID_W-1:0]      w_grant;
  logic                 w_any_req;
  logic [BYTE_W-1:0]    w_lane_data [NUM_REQ];
  logic                 w_own_valid;
  logic                 w_own_last;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign w_lane_data[gi] = req_data[gi*BYTE_W +: BYTE_W];
  end

  assign w_own_valid = req_valid[r_owner];
  assign w_own_last  = req_last[r_owner];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .grant   (w_grant),
    .any_req (w_any_req)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_locked_nxt  = r_locked;
    w_cnt_nxt     = r_cnt;
    w_data_nxt    = r_data;
    w_start_nxt   = 1'b0;
    w_ack_nxt     = '0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_owner_nxt  = w_grant;
          w_locked_nxt = 1'b1;
          w_rr_ptr_nxt = (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);
          w_state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_own_valid && uart_tx_fifo_ready) begin
          w_data_nxt         = w_lane_data[r_owner];
          w_start_nxt        = 1'b1;
          w_ack_nxt[r_owner] = 1'b1;
          w_cnt_nxt          = '0;
          w_state_nxt        = ST_SETTLE;
          if (w_own_last) begin
            w_locked_nxt = 1'b0;
          end
        end else if (!w_own_valid) begin
          // A full FIFO with data pending is not a stall; only an idle owner ages.
          if (r_cnt == c_cnt_max) begin
            w_locked_nxt  = 1'b0;
            w_timeout_nxt = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
          end
        end
      end
      ST_SETTLE: begin
        w_state_nxt = r_locked ? ST_ISSUE : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_locked  <= 1'b0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_start   <= 1'b0;
      r_ack     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_locked  <= w_locked_nxt;
      r_cnt     <= w_cnt_nxt;
      r_data    <= w_data_nxt;
      r_start   <= w_start_nxt;
      r_ack     <= w_ack_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign start_uart_tx = r_start;
  assign uart_tx_data  = r_data;
  assign req_ack       = r_ack;
  assign owner         = r_owner;
  assign locked        = r_locked;
  assign lock_timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int NR = 3;
  localparam int LT = 16;

  logic        system_clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ack;
  logic        uart_tx_fifo_ready;
  logic        start_uart_tx;
  logic [7:0]  uart_tx_data;
  logic [1:0]  owner;
  logic        locked;
  logic        lock_timeout;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .LOCK_TIMEOUT (LT),
    .ID_W         (2)
  ) dut (
    .system_clk         (system_clk),
    .reset_n            (reset_n),
    .req_valid          (req_valid),
    .req_data           (req_data),
    .req_last           (req_last),
    .req_ack            (req_ack),
    .uart_tx_fifo_ready (uart_tx_fifo_ready),
    .start_uart_tx      (start_uart_tx),
    .uart_tx_data       (uart_tx_data),
    .owner              (owner),
    .locked             (locked),
    .lock_timeout       (lock_timeout)
  );

  always #5 system_clk = ~system_clk;

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  last;
    logic [23:0] data;
    logic        ready;
    logic        e_start;
    logic [7:0]  e_data;
    logic [2:0]  e_ack;
    logic        e_locked;
    logic [1:0]  e_owner;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] d;
    logic       l;
  } exp_t;

  vec_t       vt [9];
  logic [8:0] strm [3][$];   // per requester: {last, byte}
  int         ptr_drv [3];
  exp_t       expq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n            = 1'b0;
    req_valid          = '0;
    req_last           = '0;
    req_data           = '0;
    uart_tx_fifo_ready = 1'b1;
    repeat (2) @(negedge system_clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge system_clk);
      if (start_uart_tx) ok = 1'b1;
    end
  endtask

  // Message-level model: each release hands the path to the next requester
  // (from the pointer, with wrap) that still has a message queued.
  task automatic build_expected();
    int   pos [3];
    int   p;
    int   found;
    exp_t e;
    pos = '{0, 0, 0};
    p   = 0;
    expq.delete();
    forever begin
      found = -1;
      for (int k = 0; k < 3; k++)
        if (found < 0 && pos[(p + k) % 3] < strm[(p + k) % 3].size()) found = (p + k) % 3;
      if (found < 0) break;
      do begin
        e.id = found;
        {e.l, e.d} = strm[found][pos[found]];
        pos[found]++;
        expq.push_back(e);
      end while (!e.l);
      p = (found + 1) % 3;
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 3; i++) begin
      if (ptr_drv[i] < strm[i].size()) begin
        req_valid[i]         = 1'b1;
        req_data[8*i +: 8]   = strm[i][ptr_drv[i]][7:0];
        req_last[i]          = strm[i][ptr_drv[i]][8];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[8*i +: 8]   = 8'h00;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic clear_streams();
    for (int i = 0; i < 3; i++) strm[i].delete();
  endtask

  task automatic load_random();
    int nm;
    int len;
    clear_streams();
    for (int i = 0; i < 3; i++) begin
      nm = $urandom_range(2, 3);
      for (int m = 0; m < nm; m++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) strm[i].push_back({(b == len - 1), 8'($urandom)});
      end
    end
  endtask

  // Requesters driven from strm, every start pulse compared to the model.
  // With the FIFO always ready, spacing is exact: 2 within a message,
  // 3 across a release, and 2 from the first valid to the first pulse.
  task automatic run_queues(input int ready_pct, input bit chk_gap, input int budget);
    int   cyc;
    int   last_start;
    bit   prev_start;
    bit   prev_last;
    exp_t e;
    ptr_drv    = '{0, 0, 0};
    cyc        = 0;
    last_start = 0;
    prev_start = 1'b0;
    prev_last  = 1'b0;
    build_expected();
    drive_reqs();
    uart_tx_fifo_ready = ($urandom_range(0, 99) < ready_pct);
    while (expq.size() > 0 && cyc < budget) begin
      @(negedge system_clk);
      cyc++;
      if (start_uart_tx) begin
        e = expq.pop_front();
        check("rq_data",   32'(uart_tx_data), 32'(e.d));
        check("rq_owner",  32'(owner), 32'(e.id));
        check("rq_ack",    32'(req_ack), 32'(1) << e.id);
        check("rq_locked", 32'(locked), 32'(!e.l));
        check("rq_b2b",    32'(prev_start), 32'd0);
        if (chk_gap) check("rq_gap", 32'(cyc - last_start), prev_last ? 32'd3 : 32'd2);
        last_start = cyc;
        prev_last  = 1'b1;
        prev_last  = e.l;
      end else begin
        check("rq_idle_ack", 32'(req_ack), 32'd0);
      end
      check("rq_no_timeout", 32'(lock_timeout), 32'd0);
      for (int i = 0; i < 3; i++) if (req_ack[i]) ptr_drv[i]++;
      prev_start = start_uart_tx;
      drive_reqs();
      uart_tx_fifo_ready = ($urandom_range(0, 99) < ready_pct);
    end
    check("rq_done", 32'(expq.size()), 32'd0);
    repeat (3) @(negedge system_clk);
    check("rq_released", 32'(locked), 32'd0);
  endtask

  initial begin
    bit ok;
    int n;
    int ns;
    int nt;
    int per [3];
    bit seen;

    // idx valid last data      rdy | start data  ack   locked owner
    vt[0] = '{3'b001, 3'b000, 24'h000074, 1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 2'd0};
    vt[1] = '{3'b001, 3'b000, 24'h000074, 1'b1, 1'b1, 8'h74, 3'b001, 1'b1, 2'd0};
    vt[2] = '{3'b001, 3'b001, 24'h000065, 1'b0, 1'b0, 8'h00, 3'b000, 1'b1, 2'd0};
    vt[3] = '{3'b001, 3'b001, 24'h000065, 1'b0, 1'b0, 8'h00, 3'b000, 1'b1, 2'd0};
    vt[4] = '{3'b001, 3'b001, 24'h000065, 1'b1, 1'b1, 8'h65, 3'b001, 1'b0, 2'd0};
    vt[5] = '{3'b010, 3'b010, 24'h003100, 1'b1, 1'b0, 8'h00, 3'b000, 1'b0, 2'd0};
    vt[6] = '{3'b010, 3'b010, 24'h003100, 1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 2'd1};
    vt[7] = '{3'b010, 3'b010, 24'h003100, 1'b1, 1'b1, 8'h31, 3'b010, 1'b0, 2'd1};
    vt[8] = '{3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 8'h00, 3'b000, 1'b0, 2'd1};

    // Reset values
    do_reset();
    check("rst_start",   32'(start_uart_tx), 32'd0);
    check("rst_data",    32'(uart_tx_data), 32'd0);
    check("rst_ack",     32'(req_ack), 32'd0);
    check("rst_owner",   32'(owner), 32'd0);
    check("rst_locked",  32'(locked), 32'd0);
    check("rst_timeout", 32'(lock_timeout), 32'd0);

    // Cycle-exact vectors
    for (int r = 0; r < 9; r++) begin
      req_valid          = vt[r].valid;
      req_last           = vt[r].last;
      req_data           = vt[r].data;
      uart_tx_fifo_ready = vt[r].ready;
      @(negedge system_clk);
      check($sformatf("vec%0d_start", r),  32'(start_uart_tx), 32'(vt[r].e_start));
      check($sformatf("vec%0d_ack", r),    32'(req_ack), 32'(vt[r].e_ack));
      check($sformatf("vec%0d_locked", r), 32'(locked), 32'(vt[r].e_locked));
      check($sformatf("vec%0d_owner", r),  32'(owner), 32'(vt[r].e_owner));
      if (vt[r].e_start) check($sformatf("vec%0d_data", r), 32'(uart_tx_data), 32'(vt[r].e_data));
    end

    // "test\r\n" from requester 0
    do_reset();
    clear_streams();
    strm[0] = '{9'h074, 9'h065, 9'h073, 9'h074, 9'h00D, 9'h10A};
    run_queues(100, 1'b1, 100);

    // Two simultaneous 3-byte messages: no interleave, 0 before 1
    do_reset();
    clear_streams();
    strm[0] = '{9'h0A1, 9'h0A2, 9'h1A3};
    strm[1] = '{9'h0B1, 9'h0B2, 9'h1B3};
    run_queues(100, 1'b1, 100);

    // Random messages, random FIFO readiness
    for (int t = 0; t < 4; t++) begin
      do_reset();
      load_random();
      run_queues(70, 1'b0, 2000);
    end

    // FIFO stalled 100 cycles mid-message
    do_reset();
    req_valid = 3'b001; req_data = 24'h0000C1; req_last = 3'b000;
    wait_start(10, ok);
    check("stall_first", 32'(ok), 32'd1);
    req_data = 24'h0000C2;
    uart_tx_fifo_ready = 1'b0;
    ns = 0; nt = 0;
    repeat (100) begin
      @(negedge system_clk);
      if (start_uart_tx) ns++;
      if (lock_timeout) nt++;
    end
    check("stall_starts", 32'(ns), 32'd0);
    check("stall_timeout", 32'(nt), 32'd0);
    check("stall_locked", 32'(locked), 32'd1);
    uart_tx_fifo_ready = 1'b1;
    @(negedge system_clk);
    check("stall_resume", 32'(start_uart_tx), 32'd1);
    check("stall_data", 32'(uart_tx_data), 32'hC2);
    req_data = 24'h0000C3; req_last = 3'b001;
    wait_start(10, ok);
    check("stall_last_seen", 32'(ok), 32'd1);
    check("stall_last_data", 32'(uart_tx_data), 32'hC3);
    check("stall_unlocked", 32'(locked), 32'd0);

    // Owner 2 stalls after one byte: SETTLE + 16 idle ISSUE cycles to release
    do_reset();
    req_valid = 3'b100; req_data = 24'h5A0000; req_last = 3'b000;
    wait_start(10, ok);
    check("to_first", 32'(ok), 32'd1);
    check("to_owner2", 32'(owner), 32'd2);
    req_valid = 3'b001; req_data = 24'h000011; req_last = 3'b001;
    n = 0; ns = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge system_clk);
      n++;
      if (lock_timeout) seen = 1'b1;
      else if (start_uart_tx || req_ack != 3'b000) ns++;
    end
    check("to_cycles", 32'(n), 32'd17);
    check("to_no_ack", 32'(ns), 32'd0);
    check("to_locked", 32'(locked), 32'd0);
    @(negedge system_clk);
    check("to_pulse_len", 32'(lock_timeout), 32'd0);
    check("to_next_owner", 32'(owner), 32'd0);
    check("to_next_locked", 32'(locked), 32'd1);
    @(negedge system_clk);
    check("to_next_start", 32'(start_uart_tx), 32'd1);
    check("to_next_data", 32'(uart_tx_data), 32'h11);
    check("to_next_ack", 32'(req_ack), 32'b001);

    // Fairness with continuous single-byte messages
    do_reset();
    req_valid = 3'b111; req_last = 3'b111; req_data = 24'hA2A1A0;
    per = '{0, 0, 0};
    n = 0; ns = 0;
    while (ns < 30 && n < 200) begin
      @(negedge system_clk);
      n++;
      if (start_uart_tx) begin
        check("fair_owner", 32'(owner), 32'(ns % 3));
        check("fair_data", 32'(uart_tx_data), 32'hA0 + 32'(ns % 3));
        per[owner]++;
        ns++;
      end
    end
    check("fair_total", 32'(ns), 32'd30);
    for (int i = 0; i < 3; i++) check($sformatf("fair_share%0d", i), 32'(per[i]), 32'd10);

    // Asynchronous reset mid-message, then requester 0 wins over 2
    do_reset();
    req_valid = 3'b010; req_data = 24'h007700; req_last = 3'b000;
    wait_start(10, ok);
    check("arst_first", 32'(ok), 32'd1);
    req_data = 24'h007800;
    wait_start(10, ok);
    check("arst_second", 32'(ok), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_start", 32'(start_uart_tx), 32'd0);
    check("arst_ack", 32'(req_ack), 32'd0);
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_owner", 32'(owner), 32'd0);
    @(negedge system_clk);
    reset_n = 1'b1;
    req_valid = 3'b101; req_data = 24'h030001; req_last = 3'b101;
    wait_start(10, ok);
    check("arst_after", 32'(ok), 32'd1);
    check("arst_prio_owner", 32'(owner), 32'd0);
    check("arst_prio_data", 32'(uart_tx_data), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
